ahb_lite_slave_mem: RTL and testbench
=====================================

Name: ahb_lite_slave_mem

Overview:
AHB-Lite responder (slave) backed by an internal word-addressed memory, the counterpart to the team's AHB-Lite master. It decodes address/data-phase pipelined transfers and performs byte, halfword or word accesses with byte-lane merging. It inserts a configurable number of wait states and returns the two-cycle ERROR response for illegal accesses. It sits behind the interconnect decoder as a scratch RAM and as the bench target for master verification.

Parameters:
ADDR_WIDTH, 32, haddr width
DATA_WIDTH, 32, hwdata/hrdata width (32 or 64)
MEM_DEPTH, 256, number of DATA_WIDTH words; byte range = MEM_DEPTH*DATA_WIDTH/8
WAIT_STATES, 0, wait cycles inserted per OKAY data phase (0..15)

Ports:
hclk  in  1  system clock
hreset  in  1  asynchronous active-low reset
hsel  in  1  slave select from decoder
haddr  in  ADDR_WIDTH  transfer address
htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
hwrite  in  1  1=write, 0=read
hsize  in  3  transfer size (0=byte, 1=half, 2=word, 3=dword)
hburst  in  3  burst type; informational only, not decoded
hwdata  in  DATA_WIDTH  write data (data phase)
hready  in  1  bus-level ready; qualifies the address phase
hreadyout  out  1  slave ready for the current data phase
hresp  out  2  OKAY=00, ERROR=01
hrdata  out  DATA_WIDTH  read data

Behaviour:
- Reset (hreset=0, async): state=IDLE, hreadyout=1, hresp=OKAY, hrdata=0, wait counter=0, captured controls cleared. Memory contents are not reset and are retained across reset.
- Address phase accepted when hsel & hready & htrans[1]. On acceptance capture haddr, hwrite and hsize into registers.
- Accepted transfers are checked for three error conditions:
  - out-of-range: haddr >= byte range
  - oversize: (8<<hsize) > DATA_WIDTH
  - misaligned: haddr not a multiple of (1<<hsize)
- Any error routes the transfer to the ERR path; otherwise it goes to WAIT (WAIT_STATES>0) or DONE.
- BUSY, IDLE, or hsel=0 with hready=1: no transfer; next cycle hreadyout=1, hresp=OKAY.
- FSM states:
  - IDLE: no data phase pending; hreadyout=1, OKAY.
  - WAIT: hreadyout=0, OKAY. The counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0 go to DONE.
  - DONE: hreadyout=1, OKAY. The transfer completes this cycle; a new address phase may be accepted in the same cycle (pipelined), returning to WAIT/DONE/ERR1, else IDLE.
  - ERR1: hreadyout=0, hresp=ERROR; always goes to ERR2.
  - ERR2: hreadyout=1, hresp=ERROR. Any address phase accepted this cycle is processed normally; a master that cancels drives IDLE.
- Latency: WAIT_STATES=0 gives a one-cycle data phase; N gives N+1 cycles; errors always take exactly 2 cycles.
- Write: committed on the rising edge ending DONE.
  - Word index = addr_q / (DATA_WIDTH/8).
  - Byte lanes are little-endian: lanes addr_q[low bits] through +(1<<hsize)-1 take the corresponding hwdata bytes; other lanes are unchanged.
  - Errored writes never modify memory.
- Read: during a read data phase, hrdata = mem[word index] driven combinationally from registered state, with all lanes presented; the master extracts its lanes. Outside read data phases and during ERR states, hrdata=0.
- Read-after-write: a write in DONE followed by a pipelined read of the same address returns the new data.
- hresp, hreadyout and hrdata depend only on registered state; there are no combinational paths from inputs to outputs except the memory read mux.
- Reset asserted mid-transfer aborts it: no memory write, and outputs return to reset values immediately.

Decomposition:
- Shared package ahb_lite_pkg holds:
  - HTRANS encodings
  - HRESP encodings
  - HBURST encodings
  - HSIZE encodings
  - slave FSM state encoding
  - byte-lane mask helper function
- The master is retrofitted to import the same package.
- One natural sub-module: ahb_lite_byte_ram, a MEM_DEPTH x DATA_WIDTH array with per-byte write enables and an asynchronous read port.

Test Plan:
- Word write then read, WAIT_STATES=0: NONSEQ write 0x10 with 0xDEADBEEF, then NONSEQ read 0x10 -> hreadyout stays 1, hresp=00, hrdata=0xDEADBEEF in the read data phase.
- Byte/half lanes: preload 0x11223344 at 0x20, write byte 0xAA at 0x21, then halfword 0xBBCC at 0x22 -> word read at 0x20 returns 0xBBCCAA44.
- Wait states, WAIT_STATES=2: read -> hreadyout=0 for 2 cycles, then 1 with data. Back-to-back pipelined write+read to the same address returns the written value.
- Errors: read at byte range (0x400 for defaults) -> hreadyout 0 then 1, hresp=01 both cycles. Misaligned word write at 0x02 -> same, and memory unchanged.
- INCR4 burst writes 0x30..0x3C with hsel, followed by a BUSY cycle mid-burst -> BUSY gets a zero-wait OKAY, all four words are stored, and readback matches.
- Reset in WAIT: assert hreset=0 during a write wait state -> immediate hreadyout=1, hresp=00, hrdata=0, and the target word is unchanged.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite definitions: bus encodings, slave FSM states and the
// byte-lane mask helper used by both the master and the memory slave.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HALF  = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011
    } hsize_e;

    typedef enum logic [2:0] {
        SLV_IDLE,
        SLV_WAIT,
        SLV_DONE,
        SLV_ERR1,
        SLV_ERR2
    } slv_state_t;

    // Byte enables for a (1<<size)-byte access starting at byte lane 'offset'
    // of an up-to-64-bit data bus. Only meaningful for legal, aligned sizes.
    function automatic logic [7:0] lane_mask(input logic [2:0] size,
                                             input logic [2:0] offset);
        logic [15:0] ones;
        ones = (16'd1 << (16'd1 << size)) - 16'd1;
        return 8'(ones << offset);
    endfunction

endpackage

// File: rtl/ahb_lite_slave_mem_if.sv
// AHB-Lite bus bundle between a master/interconnect and the memory slave.
interface ahb_lite_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic [1:0]            hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_lite_byte_ram.sv
// MEM_DEPTH x DATA_WIDTH storage with per-byte write enables and an
// asynchronous read port. Contents are deliberately not reset.
module ahb_lite_byte_ram #(
    parameter int MEM_DEPTH  = 256,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [DATA_WIDTH/8-1:0]      be_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]        rdata_o
);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Merge only the enabled byte lanes into the addressed word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite memory slave: pipelined address/data phases, configurable wait
// states, two-cycle ERROR response, byte-lane merging into a word RAM.
module ahb_lite_slave_mem
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic hclk,
    input  logic hreset,
    ahb_lite_slave_mem_if.slave bus
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int LOW_W  = OFF_W + MEM_AW;
    localparam logic [ADDR_WIDTH:0] BYTE_RANGE = (ADDR_WIDTH+1)'(MEM_DEPTH * NB);
    localparam logic [31:0] DW_BITS = 32'(DATA_WIDTH);
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slv_state_t        state_q, state_d;
    logic              hready_q, hready_d;
    logic [1:0]        hresp_q, hresp_d;
    logic [LOW_W-1:0]  addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;
    logic [3:0]        cnt_q, cnt_d;

    logic                  accept;
    logic                  out_of_range;
    logic                  oversize;
    logic                  misaligned;
    logic [31:0]           size_bits;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [7:0]            lane_mask8;
    logic                  ram_we;
    logic                  rd_phase;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  unused_bits;

    // Address-phase qualification and legality checks on the live bus.
    assign accept       = bus.hsel & bus.hready & bus.htrans[1];
    assign out_of_range = {1'b0, bus.haddr} >= BYTE_RANGE;
    assign size_bits    = 32'd8 << bus.hsize;
    assign oversize     = size_bits > DW_BITS;
    assign align_mask   = (ADDR_WIDTH'(1) << bus.hsize) - ADDR_WIDTH'(1);
    assign misaligned   = (bus.haddr & align_mask) != '0;

    // Next-state decode; outputs are computed for the coming cycle so they
    // leave the block as plain registers.
    always_comb begin
        state_d  = state_q;
        hready_d = hready_q;
        hresp_d  = hresp_q;
        addr_d   = addr_q;
        write_d  = write_q;
        size_d   = size_q;
        cnt_d    = cnt_q;
        case (state_q)
            SLV_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = SLV_DONE;
                    hready_d = 1'b1;
                    hresp_d  = HRESP_OKAY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SLV_ERR1: begin
                state_d  = SLV_ERR2;
                hready_d = 1'b1;
                hresp_d  = HRESP_ERROR;
            end
            default: begin
                // IDLE, DONE and ERR2 can all take a new address phase.
                if (accept) begin
                    addr_d  = bus.haddr[LOW_W-1:0];
                    write_d = bus.hwrite;
                    size_d  = bus.hsize;
                    if (out_of_range || oversize || misaligned) begin
                        state_d  = SLV_ERR1;
                        hready_d = 1'b0;
                        hresp_d  = HRESP_ERROR;
                    end else if (WAIT_STATES > 0) begin
                        state_d  = SLV_WAIT;
                        cnt_d    = WS_LOAD;
                        hready_d = 1'b0;
                        hresp_d  = HRESP_OKAY;
                    end else begin
                        state_d  = SLV_DONE;
                        hready_d = 1'b1;
                        hresp_d  = HRESP_OKAY;
                    end
                end else begin
                    state_d  = SLV_IDLE;
                    hready_d = 1'b1;
                    hresp_d  = HRESP_OKAY;
                end
            end
        endcase
    end

    // Slave FSM, captured transfer controls and registered bus outputs.
    always_ff @(posedge hclk or negedge hreset) begin
        if (!hreset) begin
            state_q  <= SLV_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            cnt_q    <= cnt_d;
        end
    end

    // Writes land at the edge that ends the DONE cycle, using that cycle's hwdata.
    assign ram_we     = (state_q == SLV_DONE) && write_q;
    assign lane_mask8 = lane_mask(size_q, 3'(addr_q[OFF_W-1:0]));
    assign rd_phase   = ((state_q == SLV_WAIT) || (state_q == SLV_DONE)) && !write_q;

    ahb_lite_byte_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk_i  (hclk),
        .we_i   (ram_we),
        .be_i   (lane_mask8[NB-1:0]),
        .waddr_i(addr_q[LOW_W-1:OFF_W]),
        .wdata_i(bus.hwdata),
        .raddr_i(addr_q[LOW_W-1:OFF_W]),
        .rdata_o(ram_rdata)
    );

    assign bus.hreadyout = hready_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = rd_phase ? ram_rdata : '0;

    // hburst is informational and htrans[0] does not affect acceptance.
    assign unused_bits = ^{bus.hburst, bus.htrans[0], lane_mask8};

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Directed bench: one slave with zero wait states, one with two.
module tb_ahb_lite_slave_mem;
    import ahb_lite_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset = 1'b0;
    logic        hsel0 = 1'b0;
    logic        hsel2 = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = HSIZE_WORD;
    logic [2:0]  hburst = HBURST_SINGLE;
    logic [31:0] hwdata = '0;

    int checks = 0;
    int passed = 0;

    always #5 hclk = ~hclk;

    ahb_lite_slave_mem_if bus0 ();
    ahb_lite_slave_mem_if bus2 ();

    assign bus0.hsel   = hsel0;
    assign bus0.haddr  = haddr;
    assign bus0.htrans = htrans;
    assign bus0.hwrite = hwrite;
    assign bus0.hsize  = hsize;
    assign bus0.hburst = hburst;
    assign bus0.hwdata = hwdata;
    assign bus0.hready = bus0.hreadyout;

    assign bus2.hsel   = hsel2;
    assign bus2.haddr  = haddr;
    assign bus2.htrans = htrans;
    assign bus2.hwrite = hwrite;
    assign bus2.hsize  = hsize;
    assign bus2.hburst = hburst;
    assign bus2.hwdata = hwdata;
    assign bus2.hready = bus2.hreadyout;

    ahb_lite_slave_mem #(.WAIT_STATES(0)) dut0 (
        .hclk  (hclk),
        .hreset(hreset),
        .bus   (bus0)
    );

    ahb_lite_slave_mem #(.WAIT_STATES(2)) dut2 (
        .hclk  (hclk),
        .hreset(hreset),
        .bus   (bus2)
    );

    function automatic logic rdy(input int t);
        return (t == 0) ? bus0.hreadyout : bus2.hreadyout;
    endfunction

    function automatic logic [1:0] rsp(input int t);
        return (t == 0) ? bus0.hresp : bus2.hresp;
    endfunction

    function automatic logic [31:0] rdt(input int t);
        return (t == 0) ? bus0.hrdata : bus2.hrdata;
    endfunction

    // Drive one bus cycle from a negedge and advance to the next negedge.
    task automatic step(input int t, input logic [1:0] tr, input logic [31:0] a,
                        input logic w, input logic [2:0] sz, input logic [31:0] wd);
        hsel0  = (t == 0);
        hsel2  = (t == 1);
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        hwdata = wd;
        @(negedge hclk);
    endtask

    task automatic test_reset();
        hreset = 1'b0;
        step(0, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
        step(0, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
        for (int t = 0; t < 2; t++) begin
            checks++;
            if (rdy(t) !== 1'b1) $display("FAIL reset_ready dut%0d got=%0b exp=1", t, rdy(t));
            else passed++;
            checks++;
            if (rsp(t) !== 2'b00) $display("FAIL reset_resp dut%0d got=%0b exp=00", t, rsp(t));
            else passed++;
            checks++;
            if (rdt(t) !== 32'h0) $display("FAIL reset_rdata dut%0d got=%h exp=0", t, rdt(t));
            else passed++;
        end
        hreset = 1'b1;
        step(0, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
    endtask

    task automatic test_word_rw();
        step(0, HTRANS_NONSEQ, 32'h10, 1, HSIZE_WORD, 0);
        checks++;
        if (rdy(0) !== 1'b1 || rsp(0) !== 2'b00)
            $display("FAIL word_wr_phase got rdy=%0b resp=%0b exp rdy=1 resp=00", rdy(0), rsp(0));
        else passed++;
        step(0, HTRANS_NONSEQ, 32'h10, 0, HSIZE_WORD, 32'hDEADBEEF);
        checks++;
        if (rdy(0) !== 1'b1 || rsp(0) !== 2'b00)
            $display("FAIL word_rd_phase got rdy=%0b resp=%0b exp rdy=1 resp=00", rdy(0), rsp(0));
        else passed++;
        checks++;
        if (rdt(0) !== 32'hDEADBEEF) $display("FAIL word_rd_data got=%h exp=deadbeef", rdt(0));
        else passed++;
        step(0, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
        checks++;
        if (rdt(0) !== 32'h0) $display("FAIL idle_rdata got=%h exp=0", rdt(0));
        else passed++;
    endtask

    task automatic test_lanes();
        step(0, HTRANS_NONSEQ, 32'h20, 1, HSIZE_WORD, 0);
        step(0, HTRANS_NONSEQ, 32'h21, 1, HSIZE_BYTE, 32'h11223344);
        step(0, HTRANS_NONSEQ, 32'h22, 1, HSIZE_HALF, 32'h0000AA00);
        step(0, HTRANS_NONSEQ, 32'h20, 0, HSIZE_WORD, 32'hBBCC0000);
        checks++;
        if (rdt(0) !== 32'hBBCCAA44) $display("FAIL lanes_word got=%h exp=bbccaa44", rdt(0));
        else passed++;
        step(0, HTRANS_NONSEQ, 32'h21, 0, HSIZE_BYTE, 0);
        checks++;
        if (rdt(0) !== 32'hBBCCAA44) $display("FAIL lanes_byte_read got=%h exp=bbccaa44", rdt(0));
        else passed++;
        step(0, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
    endtask

    task automatic test_wait_states();
        step(1, HTRANS_NONSEQ, 32'h40, 1, HSIZE_WORD, 0);
        checks++;
        if (rdy(1) !== 1'b0) $display("FAIL ws_wr_wait1 got=%0b exp=0", rdy(1));
        else passed++;
        step(1, HTRANS_NONSEQ, 32'h40, 0, HSIZE_WORD, 32'h5A5A1234);
        checks++;
        if (rdy(1) !== 1'b0) $display("FAIL ws_wr_wait2 got=%0b exp=0", rdy(1));
        else passed++;
        step(1, HTRANS_NONSEQ, 32'h40, 0, HSIZE_WORD, 32'h5A5A1234);
        checks++;
        if (rdy(1) !== 1'b1 || rsp(1) !== 2'b00)
            $display("FAIL ws_wr_done got rdy=%0b resp=%0b exp rdy=1 resp=00", rdy(1), rsp(1));
        else passed++;
        step(1, HTRANS_NONSEQ, 32'h40, 0, HSIZE_WORD, 32'h5A5A1234);
        checks++;
        if (rdy(1) !== 1'b0) $display("FAIL ws_rd_wait1 got=%0b exp=0", rdy(1));
        else passed++;
        step(1, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
        checks++;
        if (rdy(1) !== 1'b0) $display("FAIL ws_rd_wait2 got=%0b exp=0", rdy(1));
        else passed++;
        step(1, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
        checks++;
        if (rdy(1) !== 1'b1 || rdt(1) !== 32'h5A5A1234)
            $display("FAIL ws_rd_done got rdy=%0b data=%h exp rdy=1 data=5a5a1234", rdy(1), rdt(1));
        else passed++;
        step(1, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
    endtask

    task automatic test_errors();
        step(0, HTRANS_NONSEQ, 32'h400, 0, HSIZE_WORD, 0);
        checks++;
        if (rdy(0) !== 1'b0 || rsp(0) !== 2'b01 || rdt(0) !== 32'h0)
            $display("FAIL range_err1 got rdy=%0b resp=%0b data=%h exp rdy=0 resp=01 data=0",
                     rdy(0), rsp(0), rdt(0));
        else passed++;
        step(0, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
        checks++;
        if (rdy(0) !== 1'b1 || rsp(0) !== 2'b01)
            $display("FAIL range_err2 got rdy=%0b resp=%0b exp rdy=1 resp=01", rdy(0), rsp(0));
        else passed++;
        step(0, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
        checks++;
        if (rdy(0) !== 1'b1 || rsp(0) !== 2'b00)
            $display("FAIL after_err got rdy=%0b resp=%0b exp rdy=1 resp=00", rdy(0), rsp(0));
        else passed++;
        step(0, HTRANS_NONSEQ, 32'h00, 1, HSIZE_WORD, 0);
        step(0, HTRANS_NONSEQ, 32'h02, 1, HSIZE_WORD, 32'hCAFEF00D);
        checks++;
        if (rdy(0) !== 1'b0 || rsp(0) !== 2'b01)
            $display("FAIL misalign_err1 got rdy=%0b resp=%0b exp rdy=0 resp=01", rdy(0), rsp(0));
        else passed++;
        step(0, HTRANS_IDLE, 0, 0, HSIZE_WORD, 32'hFFFFFFFF);
        checks++;
        if (rdy(0) !== 1'b1 || rsp(0) !== 2'b01)
            $display("FAIL misalign_err2 got rdy=%0b resp=%0b exp rdy=1 resp=01", rdy(0), rsp(0));
        else passed++;
        step(0, HTRANS_NONSEQ, 32'h00, 0, HSIZE_WORD, 32'hFFFFFFFF);
        checks++;
        if (rdt(0) !== 32'hCAFEF00D) $display("FAIL misalign_mem got=%h exp=cafef00d", rdt(0));
        else passed++;
        step(0, HTRANS_NONSEQ, 32'h08, 0, HSIZE_DWORD, 0);
        checks++;
        if (rdy(0) !== 1'b0 || rsp(0) !== 2'b01)
            $display("FAIL oversize_err1 got rdy=%0b resp=%0b exp rdy=0 resp=01", rdy(0), rsp(0));
        else passed++;
        step(0, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
        step(0, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
    endtask

    task automatic test_burst();
        logic [31:0] d [4];
        d[0] = 32'h1111_0030;
        d[1] = 32'h2222_0034;
        d[2] = 32'h3333_0038;
        d[3] = 32'h4444_003C;
        hburst = HBURST_INCR4;
        step(0, HTRANS_NONSEQ, 32'h30, 1, HSIZE_WORD, 0);
        step(0, HTRANS_SEQ,    32'h34, 1, HSIZE_WORD, d[0]);
        step(0, HTRANS_BUSY,   32'h38, 1, HSIZE_WORD, d[1]);
        checks++;
        if (rdy(0) !== 1'b1 || rsp(0) !== 2'b00)
            $display("FAIL busy_okay got rdy=%0b resp=%0b exp rdy=1 resp=00", rdy(0), rsp(0));
        else passed++;
        step(0, HTRANS_SEQ,    32'h38, 1, HSIZE_WORD, 0);
        step(0, HTRANS_SEQ,    32'h3C, 1, HSIZE_WORD, d[2]);
        step(0, HTRANS_IDLE,   0,      0, HSIZE_WORD, d[3]);
        hburst = HBURST_SINGLE;
        step(0, HTRANS_NONSEQ, 32'h30, 0, HSIZE_WORD, 0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rdt(0) !== d[k]) $display("FAIL burst_word%0d got=%h exp=%h", k, rdt(0), d[k]);
            else passed++;
            if (k < 3) step(0, HTRANS_NONSEQ, 32'h34 + 32'(k * 4), 0, HSIZE_WORD, 0);
            else       step(0, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
        end
    endtask

    task automatic test_reset_in_wait();
        step(1, HTRANS_NONSEQ, 32'h44, 1, HSIZE_WORD, 0);
        for (int k = 0; k < 3; k++) step(1, HTRANS_IDLE, 0, 0, HSIZE_WORD, 32'h01020304);
        step(1, HTRANS_NONSEQ, 32'h44, 1, HSIZE_WORD, 0);
        hsel2  = 1'b0;
        htrans = HTRANS_IDLE;
        hwdata = 32'hFFFFFFFF;
        hreset = 1'b0;
        #1;
        checks++;
        if (rdy(1) !== 1'b1 || rsp(1) !== 2'b00 || rdt(1) !== 32'h0)
            $display("FAIL rst_wait_outputs got rdy=%0b resp=%0b data=%h exp rdy=1 resp=00 data=0",
                     rdy(1), rsp(1), rdt(1));
        else passed++;
        @(negedge hclk);
        @(negedge hclk);
        hreset = 1'b1;
        step(1, HTRANS_NONSEQ, 32'h44, 0, HSIZE_WORD, 0);
        step(1, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
        step(1, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
        checks++;
        if (rdy(1) !== 1'b1 || rdt(1) !== 32'h01020304)
            $display("FAIL rst_wait_mem got rdy=%0b data=%h exp rdy=1 data=01020304", rdy(1), rdt(1));
        else passed++;
        step(1, HTRANS_IDLE, 0, 0, HSIZE_WORD, 0);
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_lanes();
        test_wait_states();
        test_errors();
        test_burst();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

endmodule
